// File: rtl/cpu_pkg.sv
// Shared encoding constants and load-FSM types for the RV32I subset.
// ENC_NOP_PAD_EN adds the NOP-padding state to the loader FSM.
package cpu_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [3:0] {
        OPC_ADDI = 4'd0,
        OPC_XORI = 4'd1,
        OPC_ORI  = 4'd2,
        OPC_ANDI = 4'd3,
        OPC_ADD  = 4'd4,
        OPC_XOR  = 4'd5,
        OPC_OR   = 4'd6,
        OPC_AND  = 4'd7,
        OPC_SW   = 4'd8,
        OPC_BNE  = 4'd9,
        OPC_BEQ  = 4'd10
    } enc_op_e;

`ifdef ENC_NOP_PAD_EN
    typedef enum logic [1:0] {ST_LOAD, ST_DONE, ST_PAD} ld_state_e;
`else
    typedef enum logic [1:0] {ST_LOAD, ST_DONE} ld_state_e;
`endif

    // ALU ops are laid out so the low two op bits select the same f3 for I and R forms
    function automatic logic [2:0] alu_f3(input logic [1:0] sel);
        logic [2:0] f3;
        case (sel)
            2'd0:    f3 = F3_ADD;
            2'd1:    f3 = F3_XOR;
            2'd2:    f3 = F3_OR;
            default: f3 = F3_AND;
        endcase
        return f3;
    endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational symbolic-request to RV32I word encoder with illegal-op flag.
module instr_encode
    import cpu_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [12:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    logic [2:0] w_f3;
    // Branch offsets are halfword aligned, so imm[0] never reaches the word
    logic       w_unused_imm0;

    assign w_f3          = alu_f3(i_op[1:0]);
    assign w_unused_imm0 = i_imm[0];

    always_comb begin
        o_word    = '0;
        o_illegal = 1'b0;
        case (i_op)
            OPC_ADDI, OPC_XORI, OPC_ORI, OPC_ANDI:
                o_word = {i_imm[11:0], i_rs1, w_f3, i_rd, OP_IMM};
            OPC_ADD, OPC_XOR, OPC_OR, OPC_AND:
                o_word = {7'b0000000, i_rs2, i_rs1, w_f3, i_rd, OP_REG};
            OPC_SW:
                o_word = {i_imm[11:5], i_rs2, i_rs1, F3_SW, i_imm[4:0], OP_STORE};
            OPC_BNE:
                o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, F3_BNE,
                          i_imm[4:1], i_imm[11], OP_BRANCH};
            OPC_BEQ:
                o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, F3_BEQ,
                          i_imm[4:1], i_imm[11], OP_BRANCH};
            default:
                o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instruction requests and streams them into imem, holding the CPU in reset.
// ENC_NOP_PAD_EN: on finish, pad the remaining imem words with NOPs before releasing the CPU.
module instr_encoder_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [12:0]       in_imm,
    input  logic              finish,
    input  logic              clear,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              prog_done,
    output logic [ADDR_W:0]   word_count,
    output logic              err
);

    localparam logic [ADDR_W:0]   DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    ld_state_e         r_state, w_next;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_err;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic              w_full;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_write;
    logic              w_pad_write;
    logic [31:0]       w_enc_word;
    logic              w_enc_illegal;

    instr_encode u_enc (
        .i_op      (in_op),
        .i_rd      (in_rd),
        .i_rs1     (in_rs1),
        .i_rs2     (in_rs2),
        .i_imm     (in_imm),
        .o_word    (w_enc_word),
        .o_illegal (w_enc_illegal)
    );

    assign w_full   = (r_count == DEPTH_CNT);
    // clear wins over a same-cycle handshake: the request is dropped
    assign w_accept = in_valid && w_in_ready && !clear;
    assign w_write  = w_accept && !w_enc_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_LOAD;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_pad_write = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_in_ready = !w_full;
                if (clear)
                    w_next = ST_LOAD;
`ifdef ENC_NOP_PAD_EN
                else if (finish && !w_full)
                    w_next = ST_PAD;
`endif
                else if (finish || w_full)
                    w_next = ST_DONE;
            end
            ST_DONE: begin
                if (clear)
                    w_next = ST_LOAD;
            end
`ifdef ENC_NOP_PAD_EN
            ST_PAD: begin
                w_pad_write = !w_full && !clear;
                if (clear)
                    w_next = ST_LOAD;
                else if (w_full)
                    w_next = ST_DONE;
            end
`endif
            default: w_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= BASE;
            r_count  <= '0;
            r_err    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_we <= 1'b0;
            if (clear) begin
                r_wr_ptr <= BASE;
                r_count  <= '0;
                r_err    <= 1'b0;
            end else begin
                if (w_accept && w_enc_illegal)
                    r_err <= 1'b1;
                if (w_write || w_pad_write) begin
                    r_we     <= 1'b1;
                    r_addr   <= r_wr_ptr;
                    r_wdata  <= w_write ? w_enc_word : NOP_WORD;
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                    r_count  <= r_count + CNT_ONE;
                end
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign word_count = r_count;
    assign err        = r_err;
    assign prog_done  = (r_state == ST_DONE);
    // a write issued on the finishing edge lands while DONE; keep the CPU held through it
    assign cpu_rst_n  = (r_state == ST_DONE) && !r_we;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader; honours ENC_NOP_PAD_EN when defined.
module tb_instr_encoder_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam int NV     = 14;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        in_op = '0;
    logic [4:0]        in_rd = '0;
    logic [4:0]        in_rs1 = '0;
    logic [4:0]        in_rs2 = '0;
    logic [12:0]       in_imm = '0;
    logic              finish = 1'b0;
    logic              clear = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst_n;
    logic              prog_done;
    logic [ADDR_W:0]   word_count;
    logic              err;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [12:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [NV];
    int   n_vec = 0;
    int   n_bad = 0;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .finish     (finish),
        .clear      (clear),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .prog_done  (prog_done),
        .word_count (word_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [12:0] imm);
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
    endtask

    initial begin
        int npad;
        logic [31:0] e;

        vecs[0]  = '{4'd0,  5'd1,  5'd0,  5'd0,  13'd5,      32'h00500093}; // ADDI x1,x0,5
        vecs[1]  = '{4'd4,  5'd3,  5'd1,  5'd2,  13'd0,      32'h002081B3}; // ADD x3,x1,x2
        vecs[2]  = '{4'd8,  5'd0,  5'd1,  5'd2,  13'd8,      32'h0020A423}; // SW x2,8(x1)
        vecs[3]  = '{4'd9,  5'd0,  5'd1,  5'd2,  13'h1FFC,   32'hFE209EE3}; // BNE -4
        vecs[4]  = '{4'd10, 5'd0,  5'd1,  5'd2,  13'h1FFC,   32'hFE208EE3}; // BEQ -4
        vecs[5]  = '{4'd1,  5'd5,  5'd6,  5'd0,  13'h0FFF,   32'hFFF34293}; // XORI x5,x6,-1
        vecs[6]  = '{4'd2,  5'd7,  5'd8,  5'd0,  13'h07FF,   32'h7FF46393}; // ORI x7,x8,2047
        vecs[7]  = '{4'd3,  5'd10, 5'd11, 5'd0,  13'h00F0,   32'h0F05F513}; // ANDI
        vecs[8]  = '{4'd5,  5'd4,  5'd5,  5'd6,  13'd0,      32'h0062C233}; // XOR
        vecs[9]  = '{4'd6,  5'd31, 5'd30, 5'd29, 13'd0,      32'h01DF6FB3}; // OR
        vecs[10] = '{4'd7,  5'd1,  5'd2,  5'd3,  13'd0,      32'h003170B3}; // AND
        vecs[11] = '{4'd8,  5'd0,  5'd6,  5'd5,  13'h1FFC,   32'hFE532E23}; // SW x5,-4(x6)
        vecs[12] = '{4'd10, 5'd0,  5'd3,  5'd4,  13'd17,     32'h00418863}; // BEQ +16, bit0 ignored
        vecs[13] = '{4'd9,  5'd0,  5'd0,  5'd0,  13'h0800,   32'h000010E3}; // BNE +2048 (imm[11])

        #12;
        chk("rst_we",    imem_we,    0);
        chk("rst_addr",  imem_addr,  0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_cpu",   cpu_rst_n,  0);
        chk("rst_done",  prog_done,  0);
        chk("rst_cnt",   word_count, 0);
        chk("rst_err",   err,        0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_rdy",   in_ready,   1);

        // back-to-back encode table
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            @(negedge clk);
            chk($sformatf("v%0d_we", i),    imem_we,    1);
            chk($sformatf("v%0d_addr", i),  imem_addr,  i);
            chk($sformatf("v%0d_wdata", i), imem_wdata, vecs[i].exp);
            chk($sformatf("v%0d_cnt", i),   word_count, i + 1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle_we", imem_we, 0);

        // illegal op: accepted, no write, sticky err
        drive(4'd12, 5'd1, 5'd1, 5'd1, 13'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ill_we",  imem_we,    0);
        chk("ill_err", err,        1);
        chk("ill_cnt", word_count, NV);
        @(negedge clk);
        chk("ill_sticky", err, 1);

        // clear beats a same-cycle accept
        clear = 1'b1;
        drive(4'd0, 5'd1, 5'd0, 5'd0, 13'd5);
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clr_we",  imem_we,    0);
        chk("clr_err", err,        0);
        chk("clr_cnt", word_count, 0);
        chk("clr_rdy", in_ready,   1);

        // two words, finish with the second accept
        drive(vecs[0].op, vecs[0].rd, vecs[0].rs1, vecs[0].rs2, vecs[0].imm);
        @(negedge clk);
        chk("f0_addr",  imem_addr,  0);
        chk("f0_wdata", imem_wdata, 32'h00500093);
        drive(vecs[1].op, vecs[1].rd, vecs[1].rs1, vecs[1].rs2, vecs[1].imm);
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        in_valid = 1'b0;
        chk("f1_we",    imem_we,    1);
        chk("f1_addr",  imem_addr,  1);
        chk("f1_wdata", imem_wdata, 32'h002081B3);
        chk("f1_cpu",   cpu_rst_n,  0);
        chk("f1_rdy",   in_ready,   0);
`ifdef ENC_NOP_PAD_EN
        npad = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (prog_done) break;
            if (imem_we) begin
                chk("pad_addr",  imem_addr,  2 + npad);
                chk("pad_wdata", imem_wdata, 32'h00000013);
                npad++;
            end
        end
        chk("pad_done", prog_done,  1);
        chk("pad_n",    npad,       DEPTH - 2);
        chk("pad_cnt",  word_count, DEPTH);
        chk("pad_cpu",  cpu_rst_n,  1);
`else
        @(negedge clk);
        chk("fin_done", prog_done,  1);
        chk("fin_cpu",  cpu_rst_n,  1);
        chk("fin_cnt",  word_count, 2);
        chk("fin_we",   imem_we,    0);
`endif
        // DONE ignores requests and finish
        drive(4'd0, 5'd1, 5'd0, 5'd0, 13'd1);
        finish = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("dn_we",   imem_we,   0);
            chk("dn_rdy",  in_ready,  0);
            chk("dn_done", prog_done, 1);
        end
        in_valid = 1'b0;
        finish = 1'b0;

        // clear from DONE, then fill to capacity
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("re_done", prog_done,  0);
        chk("re_cpu",  cpu_rst_n,  0);
        chk("re_cnt",  word_count, 0);
        chk("re_rdy",  in_ready,   1);
        for (int i = 0; i < DEPTH; i++) begin
            drive(4'd0, 5'(i), 5'd0, 5'd0, 13'(i));
            @(negedge clk);
            e = {12'(i), 5'd0, 3'd0, 5'(i), 7'h13};
            chk($sformatf("fill%0d_addr", i),  imem_addr,  i);
            chk($sformatf("fill%0d_wdata", i), imem_wdata, e);
        end
        chk("full_rdy",  in_ready,   0);
        chk("full_we",   imem_we,    1);
        chk("full_cnt",  word_count, DEPTH);
        chk("full_cpu",  cpu_rst_n,  0);
        @(negedge clk);
        chk("full_we2",  imem_we,    0);
        chk("full_done", prog_done,  1);
        chk("full_cpu2", cpu_rst_n,  1);
        in_valid = 1'b0;

        // async reset while a write is on the bus
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        drive(vecs[1].op, vecs[1].rd, vecs[1].rs1, vecs[1].rs2, vecs[1].imm);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ar_we_pre", imem_we, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_we",    imem_we,    0);
        chk("ar_addr",  imem_addr,  0);
        chk("ar_wdata", imem_wdata, 0);
        chk("ar_cnt",   word_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_rdy",   in_ready,   1);
        chk("ar_done",  prog_done,  0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
